// File: rtl/scan_pkg.sv
// Shared types and defaults for the seven-segment display scan sequencer.
// Consumed by gen_scan_counter; SCAN_BLANK_EN selects the anti-ghosting blank phase.
package scan_pkg;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

   localparam int SCAN_N_DIGITS_DEF     = 4;
   localparam int SCAN_DIV_DEF          = 100000;
   localparam int SCAN_BLANK_CYCLES_DEF = 16;

   // Digit index width; a single-digit display still needs one bit.
   function automatic int scan_cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running modulo-DIV counter that flags its last count while enabled.
// Used for the per-digit dwell and, with SCAN_BLANK_EN, for the blank interval.
module scan_prescaler #(
   parameter int DIV = 100000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] count;

   assign tc = en && (count == LAST);

   always_ff @(posedge CLK) begin
      if (!RST_N || clr) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else if (en) begin
         count <= count + PW'(1);
      end
   end

endmodule

// File: rtl/gen_scan_counter.sv
// Multiplexed seven-segment scan sequencer: dwell prescaler, modulo-N digit counter, anode decode.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES all-off cycles after every digit advance.
module gen_scan_counter
   import scan_pkg::*;
#(
   parameter  int N_DIGITS     = SCAN_N_DIGITS_DEF,
   parameter  int DIV          = SCAN_DIV_DEF,
   parameter  int BLANK_CYCLES = SCAN_BLANK_CYCLES_DEF,
   localparam int CW           = scan_cw(N_DIGITS)
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                en,
   output logic [CW-1:0]       digit_idx,
   output logic [N_DIGITS-1:0] an_n,
   output logic                tick,
   output logic                frame
);

   localparam logic [CW-1:0] LAST_IDX = CW'(N_DIGITS - 1);

   if (N_DIGITS < 1 || N_DIGITS > 16 || DIV < 1 || BLANK_CYCLES < 1) begin : g_param_err
      $error("gen_scan_counter: illegal parameter value");
   end

   scan_state_t state;
   logic        dwell_tc;

`ifdef SCAN_BLANK_EN
   scan_state_t state_nxt;
   logic        blank_tc;

   // Each counter only runs in its own phase and is parked at zero in the other.
   scan_prescaler #(.DIV(DIV)) u_dwell (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (en && state == SHOW),
      .clr   (state == BLANK),
      .tc    (dwell_tc)
   );

   scan_prescaler #(.DIV(BLANK_CYCLES)) u_blank (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (en && state == BLANK),
      .clr   (state == SHOW),
      .tc    (blank_tc)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= SHOW;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SHOW:    if (dwell_tc) state_nxt = BLANK;
         BLANK:   if (blank_tc) state_nxt = SHOW;
         default: state_nxt = SHOW;
      endcase
   end
`else
   assign state = SHOW;

   scan_prescaler #(.DIV(DIV)) u_dwell (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (en),
      .clr   (1'b0),
      .tc    (dwell_tc)
   );
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         digit_idx <= '0;
         tick      <= 1'b0;
         frame     <= 1'b0;
      end else begin
         tick  <= dwell_tc;
         frame <= dwell_tc && (digit_idx == LAST_IDX);
         if (dwell_tc) begin
            digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + CW'(1);
         end
      end
   end

   // Decoded straight from the registered index so anodes switch on the tick edge.
   always_comb begin
      an_n = '1;
      if (state == SHOW) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == CW'(i)) an_n[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gen_scan_counter.sv
// Scoreboard bench for gen_scan_counter across four parameter sets sharing one en/reset.
// Follows SCAN_BLANK_EN the same way as the design build.
module tb_gen_scan_counter;

`ifdef SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;

   always #5 clk = ~clk;

   logic [1:0] idx_a;  logic [3:0] an_a;  logic tick_a, frame_a;
   logic [2:0] idx_b;  logic [5:0] an_b;  logic tick_b, frame_b;
   logic [0:0] idx_c;  logic [0:0] an_c;  logic tick_c, frame_c;
   logic [1:0] idx_d;  logic [3:0] an_d;  logic tick_d, frame_d;

   gen_scan_counter #(.N_DIGITS(4), .DIV(3), .BLANK_CYCLES(2)) u_a (
      .CLK(clk), .RST_N(rst_n), .en(en),
      .digit_idx(idx_a), .an_n(an_a), .tick(tick_a), .frame(frame_a));

   gen_scan_counter #(.N_DIGITS(6), .DIV(1), .BLANK_CYCLES(2)) u_b (
      .CLK(clk), .RST_N(rst_n), .en(en),
      .digit_idx(idx_b), .an_n(an_b), .tick(tick_b), .frame(frame_b));

   gen_scan_counter #(.N_DIGITS(1), .DIV(1), .BLANK_CYCLES(1)) u_c (
      .CLK(clk), .RST_N(rst_n), .en(en),
      .digit_idx(idx_c), .an_n(an_c), .tick(tick_c), .frame(frame_c));

   gen_scan_counter #(.N_DIGITS(4), .DIV(5), .BLANK_CYCLES(3)) u_d (
      .CLK(clk), .RST_N(rst_n), .en(en),
      .digit_idx(idx_d), .an_n(an_d), .tick(tick_d), .frame(frame_d));

   typedef struct {
      int          idx;
      int          pre;
      int          bcnt;
      bit          blank;
      logic        tick;
      logic        frame;
      logic [15:0] an;
   } mdl_t;

   typedef struct {
      int          inst;
      int          idx;
      logic [15:0] an;
      logic        tick;
      logic        frame;
   } exp_t;

   int   pn[4]   = '{4, 6, 1, 4};
   int   pdiv[4] = '{3, 1, 1, 5};
   int   pbc[4]  = '{2, 2, 1, 3};
   mdl_t mdl[4];
   exp_t sb[$];

   int nChecks = 0;
   int nFails  = 0;

   function automatic logic [15:0] anodes(input int idx, input bit blank, input int n);
      logic [16:0] mask;
      mask = (17'h1 << n) - 17'h1;
      if (blank) return mask[15:0];
      return mask[15:0] & ~(16'h1 << idx);
   endfunction

   // Reference behaviour of one scanner for a single clock edge.
   function automatic mdl_t step(input mdl_t s, input int n, input int div, input int bc,
                                 input logic e, input logic r);
      mdl_t t;
      t = s;
      t.tick  = 1'b0;
      t.frame = 1'b0;
      if (!r) begin
         t.idx = 0; t.pre = 0; t.bcnt = 0; t.blank = 1'b0;
      end else if (e) begin
         if (t.blank) begin
            if (t.bcnt == bc - 1) begin
               t.bcnt  = 0;
               t.blank = 1'b0;
            end else begin
               t.bcnt++;
            end
         end else if (t.pre == div - 1) begin
            t.pre   = 0;
            t.tick  = 1'b1;
            t.frame = (t.idx == n - 1);
            t.idx   = (t.idx == n - 1) ? 0 : t.idx + 1;
            t.blank = BLANK_ON;
         end else begin
            t.pre++;
         end
      end
      t.an = anodes(t.idx, t.blank, n);
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nChecks++;
      if (obs !== expv) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic compareAll();
      exp_t        e;
      logic [31:0] oi, oa;
      logic        ot, of;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.inst)
            0:       begin oi = 32'(idx_a); oa = 32'(an_a); ot = tick_a; of = frame_a; end
            1:       begin oi = 32'(idx_b); oa = 32'(an_b); ot = tick_b; of = frame_b; end
            2:       begin oi = 32'(idx_c); oa = 32'(an_c); ot = tick_c; of = frame_c; end
            default: begin oi = 32'(idx_d); oa = 32'(an_d); ot = tick_d; of = frame_d; end
         endcase
         checkOutput($sformatf("u%0d_idx", e.inst),   oi, 32'(e.idx));
         checkOutput($sformatf("u%0d_an_n", e.inst),  oa, 32'(e.an));
         checkOutput($sformatf("u%0d_tick", e.inst),  32'(ot), 32'(e.tick));
         checkOutput($sformatf("u%0d_frame", e.inst), 32'(of), 32'(e.frame));
         if (e.inst == 1) checkOutput("u1_idx_range", 32'(idx_b < 3'd6), 32'd1);
      end
   endtask

   // Check the previous edge, then drive the next cycle and queue what it must produce.
   task automatic applyStimulus(input logic e, input logic r);
      exp_t x;
      @(negedge clk);
      compareAll();
      en    = e;
      rst_n = r;
      for (int i = 0; i < 4; i++) begin
         mdl[i]  = step(mdl[i], pn[i], pdiv[i], pbc[i], e, r);
         x.inst  = i;
         x.idx   = mdl[i].idx;
         x.an    = mdl[i].an;
         x.tick  = mdl[i].tick;
         x.frame = mdl[i].frame;
         sb.push_back(x);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         mdl[i] = '{idx: 0, pre: 0, bcnt: 0, blank: 1'b0, tick: 1'b0, frame: 1'b0, an: 16'h0};
      end
      $display("[TB] start, blanking build = %0d", BLANK_ON);

      repeat (2)  applyStimulus(1'b1, 1'b0);
      // 27 enabled edges leaves the DIV=5 prescaler at 2 when the freeze starts.
      repeat (27) applyStimulus(1'b1, 1'b1);
      repeat (10) applyStimulus(1'b0, 1'b1);
      repeat (20) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      repeat (40) applyStimulus(1'b1, 1'b1);
      repeat (80) applyStimulus(($urandom % 4) != 0, ($urandom % 50) != 0);
      repeat (30) applyStimulus(1'b1, 1'b1);

      @(negedge clk);
      compareAll();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
